// File: rtl/nonce_dispatch_pkg.sv
// ============================================================================
// Module   : nonce_dispatch_pkg
// Purpose  : Shared types and helpers for the nonce dispatcher.
//            - nd_state_e : dispatcher FSM state encoding
//            - chunk_size : number of nonces in one chunk (2**log2)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nonce_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REPORT   = 2'd3
    } nd_state_e;

    function automatic logic [63:0] chunk_size(input int unsigned log2);
        chunk_size = 64'd1 << log2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nonce_dispatcher_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational N-way round-robin picker. Grants the first
//            requester at or after i_ptr, wrapping modulo N.
// Ports    : i_req  - request mask (1 = candidate)
//            i_ptr  - round-robin start position
//            o_gnt  - one-hot grant
//            o_idx  - index of the granted requester
//            o_any  - at least one requester was granted
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // (p + k) mod N without relying on N being a power of two
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        // Scan farthest-first so the candidate closest to the pointer wins
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[wrap_add(i_ptr, k)]) begin
                o_idx = wrap_add(i_ptr, k);
                o_any = 1'b1;
            end
        end
        o_gnt[o_idx] = o_any;
    end

endmodule

`default_nettype wire

// File: rtl/nonce_dispatcher.sv
// ============================================================================
// Module   : nonce_dispatcher
// Purpose  : Splits a job's nonce range into 2**CHUNK_LOG2-sized chunks and
//            issues them round-robin to idle accelerator lanes. The first
//            golden nonce aborts all other busy lanes; once every lane has
//            reported done a single result is presented.
// Ports    : job_*    - job request handshake (start/end inclusive)
//            acc_*    - per-lane start/abort pulses, chunk base/count,
//                       per-lane done/found/found-nonce inputs
//            result_* - result handshake (found flag, nonce, lane)
//            stat_*   - chunk and busy-cycle counters (only when the macro
//                       NONCE_DISPATCH_STATS_EN is defined)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_dispatcher
    import nonce_dispatch_pkg::*;
#(
    parameter int NUM_ACCELERATORS = 8,
    parameter int NONCE_WIDTH      = 32,
    parameter int CHUNK_LOG2       = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     job_valid,
    output logic                                     job_ready,
    input  logic [NONCE_WIDTH-1:0]                   job_nonce_start,
    input  logic [NONCE_WIDTH-1:0]                   job_nonce_end,
    output logic [NUM_ACCELERATORS-1:0]              acc_start,
    output logic [NONCE_WIDTH-1:0]                   acc_nonce_base,
    output logic [NONCE_WIDTH:0]                     acc_nonce_count,
    output logic [NUM_ACCELERATORS-1:0]              acc_abort,
    input  logic [NUM_ACCELERATORS-1:0]              acc_done,
    input  logic [NUM_ACCELERATORS-1:0]              acc_found,
    input  logic [NUM_ACCELERATORS*NONCE_WIDTH-1:0]  acc_found_nonce,
`ifdef NONCE_DISPATCH_STATS_EN
    output logic [31:0]                              stat_chunks,
    output logic [31:0]                              stat_cycles,
`endif
    output logic                                     result_valid,
    input  logic                                     result_ready,
    output logic                                     result_found,
    output logic [NONCE_WIDTH-1:0]                   result_nonce,
    output logic [$clog2(NUM_ACCELERATORS)-1:0]      result_lane
);

    localparam int NA  = NUM_ACCELERATORS;
    localparam int NW  = NONCE_WIDTH;
    localparam int NW1 = NONCE_WIDTH + 1;
    localparam int IW  = $clog2(NUM_ACCELERATORS);
    localparam logic [NW:0] c_CHUNK = NW1'(chunk_size(CHUNK_LOG2));

    nd_state_e     r_state, w_state_nx;
    logic [NW:0]   r_next;
    logic [NW-1:0] r_end;
    logic [NA-1:0] r_busy;
    logic [IW-1:0] r_ptr;
    logic          r_captured;
    logic [NA-1:0] r_acc_start, r_acc_abort;
    logic [NW-1:0] r_acc_base;
    logic [NW:0]   r_acc_count;
    logic          r_res_valid, r_res_found;
    logic [NW-1:0] r_res_nonce;
    logic [IW-1:0] r_res_lane;

    logic          w_accept, w_have_work, w_capture, w_issue, w_pick_any;
    logic [NW:0]   w_cur_next, w_end_ext, w_remain, w_count;
    logic [NA-1:0] w_done_v, w_found_v, w_busy_left, w_pick_gnt;
    logic [IW-1:0] w_pick_idx, w_finder;

    // The accepting cycle already issues the first chunk straight from the
    // job inputs, so the first start appears one cycle after acceptance.
    assign w_accept    = (r_state == ST_IDLE) && job_valid;
    assign w_cur_next  = w_accept ? {1'b0, job_nonce_start} : r_next;
    assign w_end_ext   = {1'b0, (w_accept ? job_nonce_end : r_end)};
    assign w_have_work = (w_cur_next <= w_end_ext);
    assign w_remain    = w_end_ext - w_cur_next + NW1'(1);
    assign w_count     = (w_remain < c_CHUNK) ? w_remain : c_CHUNK;

    // Done pulses on lanes we never started are ignored
    assign w_done_v    = acc_done & r_busy;
    assign w_found_v   = w_done_v & acc_found;
    assign w_busy_left = r_busy & ~acc_done;
    assign w_capture   = ((r_state == ST_DISPATCH) || (r_state == ST_DRAIN))
                         && !r_captured && (|w_found_v);
    // A lane freed this cycle still reads busy, so it is eligible next cycle
    assign w_issue     = (w_accept || ((r_state == ST_DISPATCH) && !w_capture))
                         && w_have_work && w_pick_any;

    rr_pick #(.N(NA), .IW(IW)) u_pick (
        .i_req (~r_busy),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Lowest-indexed finder wins a same-cycle tie
    always_comb begin
        w_finder = '0;
        for (int i = NA - 1; i >= 0; i--) begin
            if (w_found_v[i]) w_finder = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        job_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) w_state_nx = ST_DISPATCH;
            end
            ST_DISPATCH: if (w_capture || !w_have_work) w_state_nx = ST_DRAIN;
            ST_DRAIN:    if (w_busy_left == '0)         w_state_nx = ST_REPORT;
            ST_REPORT:   if (result_ready)              w_state_nx = ST_IDLE;
            default:     w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next      <= '0;
            r_end       <= '0;
            r_busy      <= '0;
            r_ptr       <= '0;
            r_captured  <= 1'b0;
            r_acc_start <= '0;
            r_acc_abort <= '0;
            r_acc_base  <= '0;
            r_acc_count <= '0;
            r_res_valid <= 1'b0;
            r_res_found <= 1'b0;
            r_res_nonce <= '0;
            r_res_lane  <= '0;
        end else begin
            r_acc_start <= '0;
            r_acc_abort <= '0;
            r_busy      <= w_busy_left | (w_issue ? w_pick_gnt : '0);
            r_res_valid <= (w_state_nx == ST_REPORT);
            if (w_accept) begin
                r_end       <= job_nonce_end;
                r_captured  <= 1'b0;
                r_res_found <= 1'b0;
                r_res_nonce <= '0;
                r_res_lane  <= '0;
            end
            if (w_issue) begin
                r_acc_start <= w_pick_gnt;
                r_acc_base  <= w_cur_next[NW-1:0];
                r_acc_count <= w_count;
                // One extra counter bit lets an end of all-ones terminate
                r_next      <= w_cur_next + w_count;
                r_ptr       <= (w_pick_idx == IW'(NA - 1)) ? '0 : w_pick_idx + IW'(1);
            end else if (w_accept) begin
                r_next      <= w_cur_next;
            end
            if (w_capture) begin
                r_captured  <= 1'b1;
                r_res_found <= 1'b1;
                r_res_nonce <= acc_found_nonce[int'(w_finder) * NW +: NW];
                r_res_lane  <= w_finder;
                // Lanes finishing this same cycle need no abort
                r_acc_abort <= w_busy_left;
            end
        end
    end

    assign acc_start       = r_acc_start;
    assign acc_abort       = r_acc_abort;
    assign acc_nonce_base  = r_acc_base;
    assign acc_nonce_count = r_acc_count;
    assign result_valid    = r_res_valid;
    assign result_found    = r_res_found;
    assign result_nonce    = r_res_nonce;
    assign result_lane     = r_res_lane;

`ifdef NONCE_DISPATCH_STATS_EN
    logic [31:0] r_stat_chunks, r_stat_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_chunks <= '0;
            r_stat_cycles <= '0;
        end else if (w_accept) begin
            r_stat_chunks <= w_issue ? 32'd1 : 32'd0;
            r_stat_cycles <= '0;
        end else if ((r_state == ST_DISPATCH) || (r_state == ST_DRAIN)) begin
            if (w_issue && (r_stat_chunks != '1)) r_stat_chunks <= r_stat_chunks + 32'd1;
            if (r_stat_cycles != '1)              r_stat_cycles <= r_stat_cycles + 32'd1;
        end
    end

    assign stat_chunks = r_stat_chunks;
    assign stat_cycles = r_stat_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nonce_dispatcher.sv
// ============================================================================
// Module   : tb_nonce_dispatcher
// Purpose  : Self-checking bench for nonce_dispatcher (4 lanes, 16-nonce
//            chunks). A behavioural accelerator array and a chunk/round-robin
//            reference model run alongside the DUT.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nonce_dispatcher;

    localparam int     N     = 4;
    localparam int     NW    = 32;
    localparam int     CL    = 4;
    localparam int     IW    = 2;
    localparam longint CHUNK = 64'd1 << CL;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            job_valid = 1'b0;
    logic            job_ready;
    logic [NW-1:0]   job_nonce_start = '0;
    logic [NW-1:0]   job_nonce_end = '0;
    logic [N-1:0]    acc_start, acc_abort;
    logic [NW-1:0]   acc_nonce_base;
    logic [NW:0]     acc_nonce_count;
    logic [N-1:0]    acc_done = '0;
    logic [N-1:0]    acc_found = '0;
    logic [N*NW-1:0] acc_found_nonce = '0;
    logic            result_valid, result_found;
    logic            result_ready = 1'b0;
    logic [NW-1:0]   result_nonce;
    logic [IW-1:0]   result_lane;
`ifdef NONCE_DISPATCH_STATS_EN
    logic [31:0]     stat_chunks, stat_cycles;
`endif

    always #5 clk = ~clk;

    nonce_dispatcher #(
        .NUM_ACCELERATORS (N),
        .NONCE_WIDTH      (NW),
        .CHUNK_LOG2       (CL)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_nonce_start (job_nonce_start),
        .job_nonce_end   (job_nonce_end),
        .acc_start       (acc_start),
        .acc_nonce_base  (acc_nonce_base),
        .acc_nonce_count (acc_nonce_count),
        .acc_abort       (acc_abort),
        .acc_done        (acc_done),
        .acc_found       (acc_found),
        .acc_found_nonce (acc_found_nonce),
`ifdef NONCE_DISPATCH_STATS_EN
        .stat_chunks     (stat_chunks),
        .stat_cycles     (stat_cycles),
`endif
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_found    (result_found),
        .result_nonce    (result_nonce),
        .result_lane     (result_lane)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    longint        cyc = 0;
    longint        m_next, m_end;
    logic [N-1:0]  m_busy;
    int            m_ptr = 0;
    bit            m_cap;
    int            m_res_lane;
    logic [NW-1:0] m_res_nonce;
    longint        done_at [N];
    bit            will_find [N];
    logic [NW-1:0] find_nonce [N];

    // Behavioural accelerators: busy lanes finish at their scheduled cycle;
    // in random mode idle lanes occasionally emit stray done/found pulses.
    task automatic drive_lanes(input int scen);
        acc_done  = '0;
        acc_found = '0;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && cyc >= done_at[i]) begin
                acc_done[i]  = 1'b1;
                acc_found[i] = will_find[i];
                acc_found_nonce[i*NW +: NW] = find_nonce[i];
            end else if (scen == 0 && !m_busy[i] && $urandom_range(0, 15) == 0) begin
                acc_done[i]  = 1'b1;
                acc_found[i] = 1'b1;
                acc_found_nonce[i*NW +: NW] = $urandom;
            end
        end
    endtask

    // scen: 0 random, 1 lane 2 finds, 2 lanes 1+3 find together, 3 no finds
    task automatic run_job(input longint s, input longint e, input int scen, input bit do_reset);
        logic [N-1:0] pre, fm, exp_abort, smask;
        longint cnt, base;
        int     lane, f, obs, since, hold;
        bit     fin, trig, allowed, complete;
        @(negedge clk);
        check_eq("job_ready_idle", job_ready, 1);
        job_valid = 1'b1;
        job_nonce_start = s[NW-1:0];
        job_nonce_end   = e[NW-1:0];
        m_next = s; m_end = e; m_busy = '0; m_cap = 0;
        obs = 0; since = 0; fin = 0; trig = 0;
        acc_done = '0; acc_found = '0;
        for (int t = 0; t < 3000 && !fin; t++) begin
            @(negedge clk);
            cyc++;
            job_valid = 1'b0;
            if (do_reset && t == 6) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_acc_start", acc_start, 0);
                check_eq("rst_acc_abort", acc_abort, 0);
                check_eq("rst_base", acc_nonce_base, 0);
                check_eq("rst_count", acc_nonce_count, 0);
                check_eq("rst_result", {result_valid, result_found, result_nonce, result_lane}, 0);
                check_eq("rst_job_ready", job_ready, 1);
                m_ptr = 0; m_busy = '0;
                acc_done = '0; acc_found = '0;
                @(negedge clk);
                rst_n = 1'b1;
                fin = 1;
            end else begin
                pre = m_busy;
                fm  = acc_done & acc_found & pre;
                allowed = !m_cap && fm == '0 && m_next <= m_end;
                if (!m_cap && fm != '0) begin
                    f = 0;
                    for (int i = N - 1; i >= 0; i--) if (fm[i]) f = i;
                    m_cap = 1; m_res_lane = f;
                    m_res_nonce = acc_found_nonce[f*NW +: NW];
                    exp_abort = pre & ~acc_done;
                    check_eq("abort_mask", acc_abort, exp_abort);
                    if (scen == 1) check_eq("abort_lane2_finder", acc_abort, 4'b1011);
                    if (scen == 2) check_eq("abort_dual_finder", acc_abort, 4'b0101);
                    for (int i = 0; i < N; i++)
                        if (exp_abort[i]) begin done_at[i] = cyc; will_find[i] = 0; end
                end else begin
                    check_eq("no_abort", acc_abort, 0);
                end
                smask = '0;
                if (allowed && pre != '1) begin
                    lane = -1;
                    for (int k = 0; k < N; k++)
                        if (lane < 0 && !pre[(m_ptr + k) % N]) lane = (m_ptr + k) % N;
                    cnt  = (m_end - m_next + 1 < CHUNK) ? (m_end - m_next + 1) : CHUNK;
                    base = m_next;
                    check_eq("start_lane", acc_start, 64'd1 << lane);
                    check_eq("start_base", acc_nonce_base, base);
                    check_eq("start_count", acc_nonce_count, cnt);
                    smask[lane] = 1'b1;
                    m_next = m_next + cnt;
                    m_ptr  = (lane + 1) % N;
                    done_at[lane]    = (scen == 1 || scen == 2) ? cyc + 1000 : cyc + $urandom_range(0, 5);
                    will_find[lane]  = (scen == 0) && ($urandom_range(0, 9) == 0);
                    find_nonce[lane] = NW'(base + longint'($urandom_range(0, int'(cnt) - 1)));
                end else begin
                    check_eq("no_start", acc_start, 0);
                end
                if (acc_start != '0) obs++;
                m_busy = (pre & ~acc_done) | smask;
                if (!trig && m_busy == '1 && scen == 1) begin
                    trig = 1; done_at[2] = cyc; will_find[2] = 1; find_nonce[2] = 32'h1234;
                end
                if (!trig && m_busy == '1 && scen == 2) begin
                    trig = 1;
                    done_at[1] = cyc; will_find[1] = 1; find_nonce[1] = 32'h1111;
                    done_at[3] = cyc; will_find[3] = 1; find_nonce[3] = 32'h3333;
                end
                complete = (m_cap || m_next > m_end) && m_busy == '0;
                if (result_valid) begin
                    acc_done = '0; acc_found = '0;
                    check_eq("valid_only_when_drained", complete, 1);
                    check_eq("result_found", result_found, m_cap);
                    check_eq("result_nonce", result_nonce, m_cap ? m_res_nonce : 0);
                    check_eq("result_lane", result_lane, m_cap ? m_res_lane : 0);
                    if (scen == 1) check_eq("lane2_nonce", {result_lane, result_nonce}, {2'd2, 32'h1234});
                    if (scen == 2) check_eq("dual_lowest", {result_lane, result_nonce}, {2'd1, 32'h1111});
                    if (!m_cap) check_eq("chunk_starts", obs, (e - s + CHUNK) / CHUNK);
                    hold = (scen == 3) ? 5 : $urandom_range(0, 5);
                    for (int h = 0; h < hold; h++) begin
                        @(negedge clk);
                        check_eq("hold_valid", result_valid, 1);
                        check_eq("hold_result", {result_found, result_nonce, result_lane},
                                 {m_cap, (m_cap ? m_res_nonce : 32'h0), (m_cap ? IW'(m_res_lane) : IW'(0))});
                        check_eq("hold_no_start", acc_start, 0);
                    end
                    result_ready = 1'b1;
                    @(negedge clk);
                    result_ready = 1'b0;
                    check_eq("valid_drop", result_valid, 0);
                    check_eq("job_ready_back", job_ready, 1);
                    fin = 1;
                end else begin
                    if (complete) since++;
                    if (since > 4) begin
                        check_eq("result_late", result_valid, 1);
                        fin = 1;
                    end
                    drive_lanes(scen);
                end
            end
        end
        check_eq("job_finished", fin, 1);
        acc_done = '0; acc_found = '0;
    endtask

    initial begin
        longint s, e;
        repeat (3) @(negedge clk);
        check_eq("reset_job_ready", job_ready, 1);
        check_eq("reset_acc", {acc_start, acc_abort, acc_nonce_base, acc_nonce_count}, 0);
        check_eq("reset_result", {result_valid, result_found, result_nonce, result_lane}, 0);
        rst_n = 1'b1;

        run_job(64'h0, 64'h3F, 3, 0);
        run_job(64'h10, 64'h2A, 3, 0);
        run_job(64'h0, 64'hFFF, 1, 0);
        run_job(64'h0, 64'hFFF, 2, 0);
        run_job(64'hFFFF_FFE5, 64'hFFFF_FFFF, 3, 0);
        run_job(64'h0, 64'hFFFF, 0, 1);
        for (int j = 0; j < 25; j++) begin
            s = (j % 5 == 4) ? 64'hFFFF_FFFF - $urandom_range(0, 60) : longint'($urandom);
            e = s + $urandom_range(0, 200);
            if (e > 64'hFFFF_FFFF) e = 64'hFFFF_FFFF;
            run_job(s, e, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nonce_dispatcher.md
# nonce_dispatcher

Job scheduler that splits one mining job's nonce range into fixed-size chunks and hands them to the parallel SHA-256 accelerators. It sits beside the accelerator array: it accepts a job from the host-side control path, issues chunks to idle accelerators in round-robin order, and collects per-chunk completions. It aborts all outstanding work on the first golden nonce and returns a single result. It never touches data memory; header data reaches the accelerators through their communication blocks as before.

## Interface
- `NUM_ACCELERATORS`, 8: number of accelerator lanes; 2–16.
- `NONCE_WIDTH`, 32: nonce width in bits.
- `CHUNK_LOG2`, 16: log2 of the chunk size in nonces; must be less than `NONCE_WIDTH`.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `job_valid` in 1: job request.
- `job_ready` out 1: job accepted when `job_valid && job_ready`.
- `job_nonce_start` in NONCE_WIDTH: first nonce, inclusive.
- `job_nonce_end` in NONCE_WIDTH: last nonce, inclusive; must be ≥ `job_nonce_start`.
- `acc_start` out NUM_ACCELERATORS: one-hot, one-cycle start pulse.
- `acc_nonce_base` out NONCE_WIDTH: chunk first nonce; valid while `acc_start` is nonzero.
- `acc_nonce_count` out NONCE_WIDTH+1: chunk length; valid while `acc_start` is nonzero.
- `acc_abort` out NUM_ACCELERATORS: one-cycle abort pulse, one bit per lane.
- `acc_done` in NUM_ACCELERATORS: per-lane completion pulse; aborted lanes also pulse.
- `acc_found` in NUM_ACCELERATORS: qualifies `acc_done`; 1 means a golden nonce was found.
- `acc_found_nonce` in NUM_ACCELERATORS*NONCE_WIDTH: per-lane found nonce, flattened; lane i occupies bits [i*NONCE_WIDTH +: NONCE_WIDTH].
- `result_valid` out 1: result available.
- `result_ready` in 1: result consumed.
- `result_found` out 1: 1 = golden nonce found; 0 = range exhausted.
- `result_nonce` out NONCE_WIDTH: the golden nonce.
- `result_lane` out $clog2(NUM_ACCELERATORS): index of the lane that found it.

## Operation
- **States:** IDLE, DISPATCH, DRAIN, REPORT.
- **IDLE**
  - `job_ready`=1.
  - On accept: `next_nonce` ← start, zero-extended to NONCE_WIDTH+1 bits; `end_nonce` ← end; go to DISPATCH.
- **Busy bitmap**
  - Bit set on `acc_start`, cleared on `acc_done`.
  - `acc_done` on a non-busy lane is ignored.
- **DISPATCH**
  - Each cycle, if `next_nonce` ≤ `end_nonce` and any lane is idle, start exactly one lane.
  - Lane choice: first idle lane at or after the round-robin pointer, wrapping. The pointer then moves to the chosen lane + 1, mod N.
  - `acc_nonce_count` = min(2^CHUNK_LOG2, `end_nonce` − `next_nonce` + 1).
  - `next_nonce` += `acc_nonce_count`. The counter is NONCE_WIDTH+1 bits, so an end of 0xFFFFFFFF terminates cleanly.
- **Found**
  - Any `acc_done & acc_found` in DISPATCH or DRAIN captures a result, first capture only.
  - Several found in the same cycle: the lowest lane index wins.
  - `acc_abort` pulses for every busy lane other than the finder. No further starts. Go to DRAIN.
- **Exhaustion:** `next_nonce` > `end_nonce` with no found result → DRAIN.
- **DRAIN**
  - Wait until the busy bitmap is all zeros, counting `acc_done` pulses from the same cycle.
  - Then go to REPORT.
  - If no result was captured, `result_found`=0, `result_nonce`=0 and `result_lane`=0.
- **REPORT**
  - `result_valid`=1, outputs held stable until `result_ready`.
  - Then go to IDLE; the round-robin pointer is kept.
- **Same-cycle done and start:** a lane freed by `acc_done` in cycle t is eligible for a start in cycle t+1, not in t.

## Timing
- **Reset values:** state IDLE; `job_ready`=1 (combinational from state); `acc_start`=0, `acc_abort`=0, `acc_nonce_base`=0, `acc_nonce_count`=0; `result_*` all 0; busy bitmap 0; pointer 0.
- **Output timing:** all outputs except `job_ready` are registered.
- **Start latency:** the first `acc_start` comes 1 cycle after job acceptance. An N-lane array is fully loaded N cycles after acceptance.
- **Abort latency:** `acc_abort` is asserted the cycle after the found `acc_done`.
- **Report latency:** `result_valid` rises the cycle after the bitmap empties. It falls the cycle after `result_valid && result_ready`.
- **Mid-job reset:** everything returns to reset values immediately. Accelerators are reset by the same `rst_n`.

## Configuration
- **Macro:** `NONCE_DISPATCH_STATS_EN`.
- **Defined:** adds output `stat_chunks` (32 bits) and output `stat_cycles` (32 bits).
  - Both are cleared on job accept.
  - `stat_chunks` counts starts; `stat_cycles` counts cycles spent outside IDLE.
  - Both saturate at all-ones and are frozen in REPORT.
- **Undefined:** neither port nor its logic exists. All other behaviour is identical.

## Structure
- **Package `nonce_dispatch_pkg`:** the state enum `nd_state_e`, and a `chunk_size(CHUNK_LOG2)` constant function.
- **Sub-module `rr_pick`:** parameterised N-way round-robin picker.
  - Inputs: request mask, pointer.
  - Outputs: one-hot grant, grant index, any-grant flag.
  - Purely combinational; the pointer register stays in `nonce_dispatcher`.

## Test plan
- **Small range:** N=4, CHUNK_LOG2=4, range 0x00–0x3F, all lanes finish with found=0.
  - Expect 4 starts, one per cycle, to lanes 0,1,2,3 with bases 0x00/0x10/0x20/0x30 and count 16.
  - Expect `result_found`=0.
- **Partial last chunk:** range 0x10–0x2A, CHUNK 16.
  - Expect counts 16 then 11.
  - Expect exactly 2 starts.
- **Found mid-job:** lane 2 finds 0x1234 with lanes 0, 1 and 3 busy.
  - Expect abort mask 0b1011 the next cycle.
  - After all lanes report done: `result_found`=1, `result_nonce`=0x1234, `result_lane`=2.
- **Simultaneous found:** lanes 1 and 3 find in the same cycle.
  - Expect `result_lane`=1.
  - Expect lane 3's nonce discarded.
- **Top-of-range wrap:** range 0xFFFFFFF0–0xFFFFFFFF, CHUNK_LOG2=3.
  - Expect 2 starts.
  - Expect no restart from 0.
  - Expect a clean REPORT.
- **Backpressure and reset:**
  - `result_ready` low for 5 cycles: outputs are held stable.
  - `rst_n` asserted in DISPATCH: all outputs return to 0 and `job_ready`=1.
